// File: rtl/demux_collector.sv
// Serial-to-parallel collector: one bit per accept steered into word position
// by in_sel or an auto-increment pointer; full word is offered on valid/ready.
module demux_collector_cell (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic wr,
   input  logic xfer,
   input  logic d,
   output logic b,
   output logic m
);
   // B is not cleared on transfer, only the mask: the delivered word lingers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         b <= 1'b0;
         m <= 1'b0;
      end else if (clear) begin
         b <= 1'b0;
         m <= 1'b0;
      end else if (xfer) begin
         m <= 1'b0;
      end else if (wr) begin
         b <= d;
         m <= 1'b1;
      end
   end
endmodule

module demux_collector #(
   parameter int N    = 8,
   parameter int SELW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            auto_mode,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_bit,
   input  logic [SELW-1:0] in_sel,
   output logic [N-1:0]    B,
   output logic [N-1:0]    fill_mask,
   output logic            out_valid,
   input  logic            out_ready
);
   typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

   state_t          state;
   logic [SELW-1:0] ptr;
   logic [SELW-1:0] addr;
   logic            accept;
   logic            xfer;
   logic [N-1:0]    wr_vec;
   logic [N-1:0]    next_mask;

   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;
   assign addr      = auto_mode ? ptr : in_sel;
   assign next_mask = fill_mask | wr_vec;

   genvar i;
   generate
      for (i = 0; i < N; i++) begin : g_bit
         assign wr_vec[i] = accept && (addr == SELW'(i));
         demux_collector_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .wr    (wr_vec[i]),
            .xfer  (xfer),
            .d     (in_bit),
            .b     (B[i]),
            .m     (fill_mask[i])
         );
      end
   endgenerate

   // ptr wraps naturally since N is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else if (clear) begin
         state     <= IDLE;
         ptr       <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE, FILL: begin
               if (accept) begin
                  if (auto_mode) ptr <= ptr + 1'b1;
                  if (&next_mask) begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                  end else begin
                     state <= FILL;
                  end
               end
            end
            HOLD: begin
               if (xfer) begin
                  state     <= IDLE;
                  ptr       <= '0;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_demux_collector.sv
// Table-driven bench for demux_collector with a scoreboard of completed words.
module tb_demux_collector;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0, auto_mode = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b0;
   logic [2:0] in_sel = 3'd0;
   logic       in_ready, out_valid;
   logic [7:0] B, fill_mask;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   always #5 clk = ~clk;

   demux_collector #(.N(8), .SELW(3)) dut (
      .clk(clk), .rst(rst), .clear(clear), .auto_mode(auto_mode),
      .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_sel(in_sel),
      .B(B), .fill_mask(fill_mask), .out_valid(out_valid), .out_ready(out_ready)
   );

   typedef struct {
      bit clr, am, iv, ib;
      logic [2:0] sel;
      bit ordy, arst;
      logic [7:0] eb, em;
      bit eov, eir;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit clr, bit am, bit iv, bit ib, logic [2:0] sel, bit ordy,
                              logic [7:0] eb, logic [7:0] em, bit eov, bit eir, bit arst = 0);
      vec_t r;
      r.clr = clr; r.am = am; r.iv = iv; r.ib = ib; r.sel = sel; r.ordy = ordy;
      r.arst = arst; r.eb = eb; r.em = em; r.eov = eov; r.eir = eir;
      return r;
   endfunction

   task automatic chk(string name, int idx, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic chk_outs(int idx, logic [7:0] eb, logic [7:0] em, bit eov, bit eir);
      chk("B", idx, B, eb);
      chk("fill_mask", idx, fill_mask, em);
      chk("out_valid", idx, {7'd0, out_valid}, {7'd0, eov});
      chk("in_ready", idx, {7'd0, in_ready}, {7'd0, eir});
   endtask

   initial begin
      bit prev_ov = 0;
      // auto stream 0,1,1,1,1,1,1,1 -> FE
      tbl.push_back(v(0,1,1,0,0,0, 8'h00,8'h01,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h02,8'h03,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h06,8'h07,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h0E,8'h0F,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h1E,8'h1F,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h3E,8'h3F,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h7E,8'h7F,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'hFE,8'hFF,1,0));
      // HOLD ignores input for 3 cycles
      for (int k = 0; k < 3; k++) tbl.push_back(v(0,1,1,1,0,0, 8'hFE,8'hFF,1,0));
      tbl.push_back(v(0,1,0,0,0,1, 8'hFE,8'h00,0,1));
      // manual 7 down to 0, bit = sel[0] -> AA
      tbl.push_back(v(0,0,1,1,7,0, 8'hFE,8'h80,0,1));
      tbl.push_back(v(0,0,1,0,6,0, 8'hBE,8'hC0,0,1));
      tbl.push_back(v(0,0,1,1,5,0, 8'hBE,8'hE0,0,1));
      tbl.push_back(v(0,0,1,0,4,0, 8'hAE,8'hF0,0,1));
      tbl.push_back(v(0,0,1,1,3,0, 8'hAE,8'hF8,0,1));
      tbl.push_back(v(0,0,1,0,2,0, 8'hAA,8'hFC,0,1));
      tbl.push_back(v(0,0,1,1,1,0, 8'hAA,8'hFE,0,1));
      tbl.push_back(v(0,0,1,0,0,0, 8'hAA,8'hFF,1,0));
      tbl.push_back(v(0,0,0,0,0,1, 8'hAA,8'h00,0,1));
      // duplicate writes to sel 3, then the other seven -> F7
      tbl.push_back(v(0,0,1,1,3,0, 8'hAA,8'h08,0,1));
      tbl.push_back(v(0,0,1,0,3,0, 8'hA2,8'h08,0,1));
      tbl.push_back(v(0,0,1,1,0,0, 8'hA3,8'h09,0,1));
      tbl.push_back(v(0,0,1,1,1,0, 8'hA3,8'h0B,0,1));
      tbl.push_back(v(0,0,1,1,2,0, 8'hA7,8'h0F,0,1));
      tbl.push_back(v(0,0,1,1,4,0, 8'hB7,8'h1F,0,1));
      tbl.push_back(v(0,0,1,1,5,0, 8'hB7,8'h3F,0,1));
      tbl.push_back(v(0,0,1,1,6,0, 8'hF7,8'h7F,0,1));
      tbl.push_back(v(0,0,1,1,7,0, 8'hF7,8'hFF,1,0));
      // transfer with in_valid held: the bit must not land
      tbl.push_back(v(0,0,1,0,0,1, 8'hF7,8'h00,0,1));
      // 4 auto accepts then clear with in_valid
      tbl.push_back(v(0,1,1,1,0,0, 8'hF7,8'h01,0,1));
      tbl.push_back(v(0,1,1,0,0,0, 8'hF5,8'h03,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'hF5,8'h07,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'hFD,8'h0F,0,1));
      tbl.push_back(v(1,1,1,1,0,0, 8'h00,8'h00,0,1));
      tbl.push_back(v(0,1,0,0,0,1, 8'h00,8'h00,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h01,8'h01,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h03,8'h03,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h07,8'h07,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h0F,8'h0F,0,1));
      // async reset between edges with mask 0F
      tbl.push_back(v(0,0,0,0,0,0, 8'h00,8'h00,0,1, 1));
      // mixed modes: manual accept must not move ptr
      tbl.push_back(v(0,1,1,1,0,0, 8'h01,8'h01,0,1));
      tbl.push_back(v(0,0,1,1,5,0, 8'h21,8'h21,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h23,8'h23,0,1));
      tbl.push_back(v(0,0,1,0,2,0, 8'h23,8'h27,0,1));
      tbl.push_back(v(0,0,1,0,3,0, 8'h23,8'h2F,0,1));
      tbl.push_back(v(0,0,1,0,4,0, 8'h23,8'h3F,0,1));
      tbl.push_back(v(0,0,1,0,6,0, 8'h23,8'h7F,0,1));
      tbl.push_back(v(0,0,1,0,7,0, 8'h23,8'hFF,1,0));
      // clear in HOLD beats a same-cycle transfer
      tbl.push_back(v(1,0,0,0,0,1, 8'h00,8'h00,0,1));
      tbl.push_back(v(0,1,1,1,0,0, 8'h01,8'h01,0,1));

      repeat (2) @(posedge clk);
      #1 chk_outs(-1, 8'h00, 8'h00, 0, 1);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].arst) begin
            in_valid = 0; out_ready = 0; clear = 0;
            #2 rst = 1'b1;
            #1 chk_outs(i, tbl[i].eb, tbl[i].em, tbl[i].eov, tbl[i].eir);
            sb.delete();
            prev_ov = 0;
            @(posedge clk);
            #1 rst = 1'b0;
            continue;
         end
         clear = tbl[i].clr; auto_mode = tbl[i].am; in_valid = tbl[i].iv;
         in_bit = tbl[i].ib; in_sel = tbl[i].sel; out_ready = tbl[i].ordy;
         if (tbl[i].clr) sb.delete();
         else if (tbl[i].eov && !prev_ov) sb.push_back(tbl[i].eb);
         prev_ov = tbl[i].eov;
         if (out_valid && out_ready && !clear) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL scoreboard row %0d: got word %h expected none", i, B);
            end else begin
               logic [7:0] w;
               w = sb.pop_front();
               chk("delivered_word", i, B, w);
            end
         end
         @(posedge clk);
         #1 chk_outs(i, tbl[i].eb, tbl[i].em, tbl[i].eov, tbl[i].eir);
      end
      in_valid = 0; clear = 0; out_ready = 0;
      // the last frame is still in progress, so nothing may be left pending
      chk("scoreboard_left", -1, 8'(sb.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
